// File: rtl/sample_window_writer.sv
// rtl/sample_window_writer.sv - circular sample-window write front end
//
// Purpose: accepts samples over a valid/ready handshake and emits registered
// write strobes into a circular buffer of DATADEPTH = 1 << DEPTHBITS entries.
// Once a full window has been written, every new write pulses window_valid
// and reports the address of the oldest sample in the window.
//
// Optional feature macro: SAMPLE_WINDOW_COUNT_EN adds a 16-bit sample_count
// output that counts accepted samples.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   in_valid     - sample present on in_data
//   in_data      - sample value
//   in_ready     - writer can accept (combinational, !hold)
//   hold         - reader busy, stalls acceptance
//   wr_en        - registered memory write strobe
//   wr_addr      - registered write address
//   wr_data      - registered write data
//   window_valid - one-cycle pulse with a write that leaves the buffer full
//   sample_count - accepted sample counter (SAMPLE_WINDOW_COUNT_EN only)
//   oldest_addr  - address of the oldest sample in the current window

module sample_window_writer #(
    parameter int DATAWIDTH = 2,
    parameter int DEPTHBITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 in_ready,
    input  logic                 hold,
    output logic                 wr_en,
    output logic [DEPTHBITS-1:0] wr_addr,
    output logic [DATAWIDTH-1:0] wr_data,
    output logic                 window_valid,
`ifdef SAMPLE_WINDOW_COUNT_EN
    output logic [15:0]          sample_count,
`endif
    output logic [DEPTHBITS-1:0] oldest_addr
);

    // Fill level that means "buffer holds a full window" (DATADEPTH).
    localparam logic [DEPTHBITS:0] FILL_FULL = {1'b1, {DEPTHBITS{1'b0}}};

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_SLIDE = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [DEPTHBITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTHBITS:0]     fill_q, fill_d;
    logic                   wr_en_q, wr_en_d;
    logic [DEPTHBITS-1:0]   wr_addr_q, wr_addr_d;
    logic [DATAWIDTH-1:0]   wr_data_q, wr_data_d;
    logic                   window_valid_q, window_valid_d;
    logic [DEPTHBITS-1:0]   oldest_addr_q, oldest_addr_d;
    logic                   accept;

    assign in_ready = !hold;
    // Reset wins over a same-cycle handshake.
    assign accept   = in_valid && in_ready && !rst;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        fill_d         = fill_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        window_valid_d = 1'b0;
        oldest_addr_d  = oldest_addr_q;

        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_data_d = in_data;
            // Rolls over naturally at DATADEPTH; the writer never stalls on full.
            wr_ptr_d  = wr_ptr_q + 1'b1;

            case (state_q)
                ST_FILL: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_d == FILL_FULL) begin
                        window_valid_d = 1'b1;
                        oldest_addr_d  = wr_ptr_q + 1'b1;
                        state_d        = ST_SLIDE;
                    end
                end
                ST_SLIDE: begin
                    // The slot just overwritten was the oldest; the next one is now oldest.
                    window_valid_d = 1'b1;
                    oldest_addr_d  = wr_ptr_q + 1'b1;
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FILL;
            wr_ptr_q       <= '0;
            fill_q         <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            window_valid_q <= 1'b0;
            oldest_addr_q  <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            fill_q         <= fill_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            window_valid_q <= window_valid_d;
            oldest_addr_q  <= oldest_addr_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign window_valid = window_valid_q;
    assign oldest_addr  = oldest_addr_q;

`ifdef SAMPLE_WINDOW_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign sample_count = count_q;
`endif

endmodule

// File: tb/tb_sample_window_writer.sv
// tb/tb_sample_window_writer.sv - scoreboard bench for sample_window_writer

module tb_sample_window_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_data;
    logic       in_ready;
    logic       hold;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [1:0] wr_data;
    logic       window_valid;
    logic [1:0] oldest_addr;
`ifdef SAMPLE_WINDOW_COUNT_EN
    logic [15:0] sample_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] addr;
        logic [1:0] data;
        logic       wv;
        logic [1:0] oldest;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    sample_window_writer #(.DATAWIDTH(2), .DEPTHBITS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .hold         (hold),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .window_valid (window_valid),
`ifdef SAMPLE_WINDOW_COUNT_EN
        .sample_count (sample_count),
`endif
        .oldest_addr  (oldest_addr)
    );

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every presented write is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected no write at %0t",
                         wr_addr, wr_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", int'(wr_addr), int'(e.addr));
                chk("wr_data", int'(wr_data), int'(e.data));
                chk("window_valid", int'(window_valid), int'(e.wv));
                chk("oldest_addr", int'(oldest_addr), int'(e.oldest));
            end
        end else if (wr_en === 1'b0) begin
            chk("wv_without_wr_en", int'(window_valid), 0);
        end
    end

    // Drive one sample; the expected write record goes to the scoreboard first.
    task automatic send(input logic [1:0] d, input logic [1:0] a,
                        input logic wv, input logic [1:0] old);
        exp_t e;
        e.addr = a; e.data = d; e.wv = wv; e.oldest = old;
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_window_valid"}, int'(window_valid), 0);
        chk({tag, "_oldest_addr"}, int'(oldest_addr), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 2'd0; hold = 1'b1;
        @(negedge clk);
        chk("in_ready_hold_in_reset", int'(in_ready), 0);
        hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_reset", int'(in_ready), 1);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill: window completes on the 4th write, oldest = 0.
        send(2'd0, 2'd0, 1'b0, 2'd0);
        send(2'd1, 2'd1, 1'b0, 2'd0);
        send(2'd2, 2'd2, 1'b0, 2'd0);
        send(2'd3, 2'd3, 1'b1, 2'd0);
        // Slide: overwrite addr 0 then 1.
        send(2'd3, 2'd0, 1'b1, 2'd1);
        send(2'd2, 2'd1, 1'b1, 2'd2);

        // Hold for 3 cycles with a pending sample.
        hold = 1'b1; in_valid = 1'b1; in_data = 2'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_wr_en", int'(wr_en), 0);
        end
        begin
            exp_t e;
            e.addr = 2'd2; e.data = 2'd2; e.wv = 1'b1; e.oldest = 2'd3;
            exp_q.push_back(e);
        end
        hold = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Gap: nothing written, address outputs hold.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("gap_wr_en", int'(wr_en), 0);
            chk("gap_window_valid", int'(window_valid), 0);
            chk("gap_wr_addr", int'(wr_addr), 2);
            chk("gap_oldest_addr", int'(oldest_addr), 3);
        end

        // Reset mid-window: restart, two accepts, then reset with a sample offered.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(2'd1, 2'd0, 1'b0, 2'd0);
        send(2'd3, 2'd1, 1'b0, 2'd0);
        rst = 1'b1; in_valid = 1'b1; in_data = 2'd2;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_zero_outputs("mid_reset");

        send(2'd2, 2'd0, 1'b0, 2'd0);
        send(2'd1, 2'd1, 1'b0, 2'd0);
        send(2'd0, 2'd2, 1'b0, 2'd0);
        send(2'd3, 2'd3, 1'b1, 2'd0);
        send(2'd1, 2'd0, 1'b1, 2'd1);
        send(2'd2, 2'd1, 1'b1, 2'd2);
        @(negedge clk);
`ifdef SAMPLE_WINDOW_COUNT_EN
        chk("sample_count_6", int'(sample_count), 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("sample_count_reset", int'(sample_count), 0);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish by %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/sample_window_writer.md
# sample_window_writer

Write-side front end for the parameterized sample memory. Accepts a stream of time-series samples over a valid/ready handshake and emits registered write strobes (address, data, enable) into a circular buffer of `DATADEPTH` entries. Once the buffer holds a full window it pulses `window_valid` for every new sample and reports the address of the oldest sample. The downstream reader walks the window from that address.

## Interface
- `DATAWIDTH`, 2: sample width in bits.
- `DEPTHBITS`, 2: address width.
- `DATADEPTH` = `1 << DEPTHBITS`: window length in samples. Derived; not overridable.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: sample present on `in_data`.
- `in_data`  in  `DATAWIDTH`: sample value.
- `in_ready`  out  1: writer can accept a sample. Combinational: `!hold`.
- `hold`  in  1: reader busy; stalls acceptance.
- `wr_en`  out  1: registered memory write strobe.
- `wr_addr`  out  `DEPTHBITS`: registered write address.
- `wr_data`  out  `DATAWIDTH`: registered write data.
- `window_valid`  out  1: one-cycle pulse, coincident with a `wr_en` that leaves the buffer full.
- `oldest_addr`  out  `DEPTHBITS`: address of the oldest sample in the current window. Meaningful only once the buffer is full.

## Operation
- Accept condition at a rising edge: `in_valid && in_ready && !rst`.
- Internal state:
  - `wr_ptr` (`DEPTHBITS` bits): next address to write.
  - `fill` (`DEPTHBITS+1` bits): saturates at `DATADEPTH`.
  - `state`: one of FILL or SLIDE.
- FILL, on accept:
  - Write the sample at `wr_ptr`.
  - `wr_ptr <= wr_ptr+1`, modulo `DATADEPTH`; `fill <= fill+1`.
  - If the new `fill` equals `DATADEPTH`: assert `window_valid`, set `oldest_addr <= wr_ptr+1` (mod), go to SLIDE.
- SLIDE, on every accept:
  - Overwrite the sample at `wr_ptr` (the oldest entry).
  - `wr_ptr <= wr_ptr+1` (mod).
  - `oldest_addr <= wr_ptr+1` (mod).
  - Assert `window_valid`.
  - Remain in SLIDE.
- No accept:
  - `wr_en`, `window_valid` <= 0.
  - `wr_addr`, `wr_data`, `oldest_addr` hold their previous values.
- Wrap-around: `wr_ptr` rolls from `DATADEPTH-1` to 0 with no flag or stall. The writer never blocks on full; it overwrites.
- `hold`: forces `in_ready` low the same cycle. No sample is lost or duplicated; the producer must keep `in_valid`/`in_data` stable until accepted.
- Reset: `wr_ptr`, `fill`, `wr_en`, `wr_addr`, `wr_data`, `window_valid`, `oldest_addr` all go to 0; `state` goes to FILL.
  - Reset mid-window discards the partial window; the next accept writes address 0.
  - `rst` has priority over an accept in the same cycle.
  - `in_ready` follows `hold` even during reset, but no accept occurs while `rst` is high.
- `DATADEPTH==1` (`DEPTHBITS=0` unsupported): not supported; `DEPTHBITS` must be ≥1.

## Timing
- Latency: a sample accepted at edge N appears on `wr_en`/`wr_addr`/`wr_data` during cycle N to N+1. That is one registered stage, and the memory captures it at edge N+1.
- `window_valid` and the updated `oldest_addr` become visible in the same cycle as the corresponding `wr_en`.
- The reader may start at `oldest_addr` from the cycle after the `window_valid` pulse. The memory read data is then current, including the write just committed.
- Throughput: one sample per cycle when `hold=0`. Back-to-back accepts produce continuous `wr_en` high.
- Output reset values (all 0): `in_ready` = `!hold`; `wr_en`, `wr_addr`, `wr_data`, `window_valid`, `oldest_addr` = 0.

## Configuration
- `SAMPLE_WINDOW_COUNT_EN`:
  - Defined: adds output `sample_count` (16 bits).
    - Increments on every accept and wraps at 2^16.
    - Reset to 0 by `rst`.
    - Registered; it updates in the same cycle as `wr_en`.
  - Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
Run with `DATAWIDTH=2`, `DEPTHBITS=2`.
- **Fill:** after reset, stream 0,1,2,3 with `hold=0`.
  - `wr_addr` 0,1,2,3 with `wr_data` 0,1,2,3.
  - `window_valid` high only with the 4th write.
  - `oldest_addr` = 0 at that point.
- **Slide:** continue with samples 3,2.
  - Writes go to addr 0 then 1.
  - `window_valid` pulses on each.
  - `oldest_addr` = 1 then 2.
- **Hold:** assert `hold` for 3 cycles while `in_valid=1`, `in_data=2`.
  - `in_ready=0` and `wr_en=0` for those 3 cycles.
  - After release, exactly one write of 2 occurs.
- **Gap:** set `in_valid=0` for 2 cycles.
  - `wr_en` and `window_valid` are 0.
  - `wr_addr`, `oldest_addr` unchanged.
- **Reset mid-window:** after 2 accepts, pulse `rst` in the same cycle as `in_valid=1`.
  - That sample is not written; all outputs are 0.
  - The next accept writes addr 0, and `window_valid` stays low until 4 more accepts.
- **With `SAMPLE_WINDOW_COUNT_EN`:** 6 accepts then reset.
  - `sample_count` reads 6, then 0.
